// File: rtl/output_vc_state_tracker.sv
// -----------------------------------------------------------------------------
// output_vc_state_tracker
//
// Purpose:
//   Per-output-port VC state and credit tracker. This block is the producer
//   side of the gather VC allocator handshake. It advertises which output VCs
//   are free (outVCAvailable) and consumes the allocator's one-cycle grant
//   pulses (outVCAvailableReset). It also tracks downstream buffer credits per
//   VC from departing link flits and returned credits. A VC is re-armed once
//   its packet has left and the downstream buffer has fully drained.
//   One instance is used per router output port.
//
// Parameters:
//   CN         number of VCs per port (matches allocator width)
//   BUF_DEPTH  downstream per-VC buffer depth in flits (= initial credits), >=1
//   CW         credit counter width, derived as $clog2(BUF_DEPTH+1)
//
// Ports:
//   clk                  in   1      clock (single domain)
//   rst                  in   1      synchronous reset, active-high
//   outVCAvailableReset  in   CN     allocator grant pulse per output VC
//   flitOutValid         in   1      a flit leaves on the output link this cycle
//   flitOutVC            in   CN     one-hot VC of the departing flit
//   flitOutTail          in   1      departing flit is a tail (single flit = tail)
//   creditIn             in   CN     per-VC credit return pulse, one slot each
//   outVCAvailable       out  CN     VC is free for allocation
//   outVCHasCredit       out  CN     credit count is non-zero
//   creditCnt            out  CN*CW  flattened credit counters, VC0 in the LSBs
//   protoErr             out  CN     sticky per-VC protocol error
//   state_dbg            out  CN*2   per-VC FSM state (IDLE=0, ALLOC=1, DRAIN=2),
//                                    VC0 in the LSBs, for observation only
//
// Build option:
//   OVC_EARLY_RELEASE_EN  when defined, a tail flit sent in ALLOC returns the VC
//                         straight to IDLE regardless of credits, so DRAIN is
//                         never entered and a VC can be reallocated while the
//                         downstream buffer still holds flits. When undefined
//                         (default), reallocation waits in DRAIN until all
//                         credits have returned.
//
// Allocator handshake:
//   outVCAvailable[v] acts as the "valid" of a free VC; outVCAvailableReset[v]
//   is the allocator's single-cycle "take" of that VC. A take is honoured only
//   when the VC is IDLE at that clock edge, and outVCAvailable[v] drops on the
//   following cycle. A take in any other state is ignored and flagged in
//   protoErr. No backpressure exists on this interface.
// -----------------------------------------------------------------------------
module output_vc_state_tracker #(
  parameter int CN        = 5,
  parameter int BUF_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CN-1:0]                        outVCAvailableReset,
  input  logic                                 flitOutValid,
  input  logic [CN-1:0]                        flitOutVC,
  input  logic                                 flitOutTail,
  input  logic [CN-1:0]                        creditIn,
  output logic [CN-1:0]                        outVCAvailable,
  output logic [CN-1:0]                        outVCHasCredit,
  output logic [CN*$clog2(BUF_DEPTH+1)-1:0]    creditCnt,
  output logic [CN-1:0]                        protoErr,
  output logic [CN*2-1:0]                      state_dbg
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    DRAIN = 2'd2
  } vc_state_t;

  vc_state_t     state_q [CN];
  logic [CW-1:0] cnt_q   [CN];
  logic [CN-1:0] err_q;

  logic [CW-1:0] cnt_nxt [CN];
  logic [CN-1:0] err_set;
  logic          flit_onehot;
  logic [CN-1:0] send_vec;
  logic [CN-1:0] bad_vec;

  // ---------------------------------------------------------------------------
  // Departing flit qualification. A flit whose VC field is not one-hot is not
  // attributed to any VC; every VC named in the malformed field is flagged.
  // ---------------------------------------------------------------------------
  always_comb begin
    flit_onehot = (flitOutVC != '0) &&
                  ((flitOutVC & (flitOutVC - CN'(1))) == '0);
    send_vec    = '0;
    bad_vec     = '0;
    if (flitOutValid) begin
      if (flit_onehot) begin
        send_vec = flitOutVC;
      end else begin
        bad_vec  = flitOutVC;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credit next-state and per-cycle error detection.
  // A send and a return on the same VC cancel exactly, even at the counter
  // limits, so they never raise an error together.
  // ---------------------------------------------------------------------------
  always_comb begin
    err_set = '0;
    for (int v = 0; v < CN; v++) begin
      cnt_nxt[v] = cnt_q[v];
      err_set[v] = bad_vec[v];

      case ({send_vec[v], creditIn[v]})
        2'b10: begin
          if (cnt_q[v] == '0) begin
            // Underflow: the link sent without a credit; hold at zero.
            err_set[v] = 1'b1;
          end else begin
            cnt_nxt[v] = cnt_q[v] - CW'(1);
          end
        end
        2'b01: begin
          if (cnt_q[v] == CNT_FULL) begin
            // Overflow: more credits returned than slots exist; saturate.
            err_set[v] = 1'b1;
          end else begin
            cnt_nxt[v] = cnt_q[v] + CW'(1);
          end
        end
        default: begin
          cnt_nxt[v] = cnt_q[v];
        end
      endcase

      // A flit on an unallocated VC is an error but still consumes a credit.
      // This includes a flit sent in the very cycle the grant arrives.
      if (send_vec[v] && (state_q[v] == IDLE)) begin
        err_set[v] = 1'b1;
      end

      // A grant for a VC that is not free is ignored and flagged.
      if (outVCAvailableReset[v] && (state_q[v] != IDLE)) begin
        err_set[v] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-VC state machine, credit counters and sticky error flags.
  // Release decisions compare against the next credit count so that a VC whose
  // last credit returns in the same cycle as the tail goes straight to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < CN; v++) begin
        state_q[v] <= IDLE;
        cnt_q[v]   <= CNT_FULL;
      end
      err_q <= '0;
    end else begin
      for (int v = 0; v < CN; v++) begin
        cnt_q[v] <= cnt_nxt[v];

        case (state_q[v])
          IDLE: begin
            if (outVCAvailableReset[v]) begin
              state_q[v] <= ALLOC;
            end
          end
          ALLOC: begin
            if (send_vec[v] && flitOutTail) begin
`ifdef OVC_EARLY_RELEASE_EN
              state_q[v] <= IDLE;
`else
              if (cnt_nxt[v] == CNT_FULL) begin
                state_q[v] <= IDLE;
              end else begin
                state_q[v] <= DRAIN;
              end
`endif
            end
          end
          DRAIN: begin
            if (cnt_nxt[v] == CNT_FULL) begin
              state_q[v] <= IDLE;
            end
          end
          default: begin
            state_q[v] <= IDLE;
          end
        endcase
      end
      err_q <= err_q | err_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Availability comes straight from the registered state;
  // credit outputs are a zero-latency view of the counter registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    outVCAvailable = '0;
    outVCHasCredit = '0;
    creditCnt      = '0;
    state_dbg      = '0;
    for (int v = 0; v < CN; v++) begin
      outVCAvailable[v]        = (state_q[v] == IDLE);
      outVCHasCredit[v]        = (cnt_q[v] != '0);
      creditCnt[v*CW +: CW]    = cnt_q[v];
      state_dbg[v*2 +: 2]      = state_q[v];
    end
  end

  assign protoErr = err_q;

endmodule

// File: tb/tb_output_vc_state_tracker.sv
// -----------------------------------------------------------------------------
// tb_output_vc_state_tracker
//
// Directed bench for output_vc_state_tracker with CN=5, BUF_DEPTH=4 (CW=3).
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// 1 time unit after the following rising edge. All expected values are written
// by hand from the behaviour of the block.
// -----------------------------------------------------------------------------
module tb_output_vc_state_tracker;

  localparam int CN = 5;
  localparam int BD = 4;
  localparam int CW = 3;

  logic              clk;
  logic              rst;
  logic [CN-1:0]     outVCAvailableReset;
  logic              flitOutValid;
  logic [CN-1:0]     flitOutVC;
  logic              flitOutTail;
  logic [CN-1:0]     creditIn;
  logic [CN-1:0]     outVCAvailable;
  logic [CN-1:0]     outVCHasCredit;
  logic [CN*CW-1:0]  creditCnt;
  logic [CN-1:0]     protoErr;
  logic [CN*2-1:0]   state_dbg;

  int total;
  int bad;

  output_vc_state_tracker #(
    .CN        (CN),
    .BUF_DEPTH (BD)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .outVCAvailableReset (outVCAvailableReset),
    .flitOutValid        (flitOutValid),
    .flitOutVC           (flitOutVC),
    .flitOutTail         (flitOutTail),
    .creditIn            (creditIn),
    .outVCAvailable      (outVCAvailable),
    .outVCHasCredit      (outVCHasCredit),
    .creditCnt           (creditCnt),
    .protoErr            (protoErr),
    .state_dbg           (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    outVCAvailableReset = '0;
    flitOutValid        = 1'b0;
    flitOutVC           = '0;
    flitOutTail         = 1'b0;
    creditIn            = '0;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int v);
    return creditCnt[v*CW +: CW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_avail",  32'(outVCAvailable), 32'h1f);
    check("rst_credit", 32'(outVCHasCredit), 32'h1f);
    check("rst_err",    32'(protoErr),       32'h0);
    check("rst_cnt",    32'(creditCnt),      32'({3'd4, 3'd4, 3'd4, 3'd4, 3'd4}));

    // Grant VC2: availability drops on the next cycle only for VC2
    outVCAvailableReset = 5'b00100;
    tick();
    idle_inputs();
    check("grant2_avail", 32'(outVCAvailable), 32'b11011);
    check("grant2_err",   32'(protoErr),       32'h0);

    // VC1: allocate, 3 flits with the last as tail, then 3 credit returns
    outVCAvailableReset = 5'b00010;
    tick();
    idle_inputs();
    check("grant1_avail", 32'(outVCAvailable), 32'b11001);
    flitOutValid = 1'b1;
    flitOutVC    = 5'b00010;
    tick();
    tick();
    flitOutTail  = 1'b1;
    tick();
    idle_inputs();
    check("vc1_cnt_after_tail", 32'(cnt_of(1)), 32'd1);
`ifdef OVC_EARLY_RELEASE_EN
    check("vc1_avail_after_tail", 32'(outVCAvailable[1]), 32'd1);
`else
    check("vc1_avail_after_tail", 32'(outVCAvailable[1]), 32'd0);
    check("vc1_state_drain",      32'(state_dbg[3:2]),    32'd2);
`endif
    creditIn = 5'b00010;
    tick();
    tick();
    check("vc1_cnt_two_returns", 32'(cnt_of(1)), 32'd3);
`ifndef OVC_EARLY_RELEASE_EN
    check("vc1_still_draining", 32'(outVCAvailable[1]), 32'd0);
`endif
    tick();
    idle_inputs();
    check("vc1_cnt_full",    32'(cnt_of(1)),         32'd4);
    check("vc1_avail_back",  32'(outVCAvailable[1]), 32'd1);
    check("vc1_err",         32'(protoErr),          32'h0);

    // VC0: bring count to 2, then send and return together for 3 cycles
    outVCAvailableReset = 5'b00001;
    tick();
    idle_inputs();
    flitOutValid = 1'b1;
    flitOutVC    = 5'b00001;
    tick();
    tick();
    check("vc0_cnt_two", 32'(cnt_of(0)), 32'd2);
    creditIn = 5'b00001;
    tick();
    tick();
    tick();
    idle_inputs();
    check("vc0_cnt_balanced", 32'(cnt_of(0)), 32'd2);
    check("vc0_err_none",     32'(protoErr),  32'h0);

    // VC3: 5 sends against depth 4
    outVCAvailableReset = 5'b01000;
    tick();
    idle_inputs();
    flitOutValid = 1'b1;
    flitOutVC    = 5'b01000;
    for (int i = 0; i < 4; i++) tick();
    check("vc3_cnt_zero",    32'(cnt_of(3)),      32'd0);
    check("vc3_hascredit",   32'(outVCHasCredit), 32'b10111);
    check("vc3_err_before",  32'(protoErr),       32'h0);
    tick();
    idle_inputs();
    check("vc3_cnt_hold",    32'(cnt_of(3)),      32'd0);
    check("vc3_err_after",   32'(protoErr),       32'b01000);

    // VC4: grant, then a second grant while allocated
    outVCAvailableReset = 5'b10000;
    tick();
    idle_inputs();
    check("vc4_avail",     32'(outVCAvailable), 32'b00010);
    check("vc4_err_first", 32'(protoErr),       32'b01000);
    outVCAvailableReset = 5'b10000;
    tick();
    idle_inputs();
    check("vc4_state_alloc", 32'(state_dbg[9:8]), 32'd1);
    check("vc4_err_regrant", 32'(protoErr),       32'b11000);

    // VC4: single-flit tail with a same-cycle credit return releases directly
    flitOutValid = 1'b1;
    flitOutVC    = 5'b10000;
    flitOutTail  = 1'b1;
    creditIn     = 5'b10000;
    tick();
    idle_inputs();
    check("vc4_release_avail", 32'(outVCAvailable), 32'b10010);
    check("vc4_release_cnt",   32'(cnt_of(4)),      32'd4);
    check("vc4_release_err",   32'(protoErr),       32'b11000);

    // VC2: credit return while already full saturates and flags
    creditIn = 5'b00100;
    tick();
    idle_inputs();
    check("vc2_sat_cnt", 32'(cnt_of(2)), 32'd4);
    check("vc2_sat_err", 32'(protoErr),  32'b11100);

    // VC1: flit while IDLE is flagged but still debits
    flitOutValid = 1'b1;
    flitOutVC    = 5'b00010;
    tick();
    idle_inputs();
    check("vc1_idle_send_cnt",   32'(cnt_of(1)),         32'd3);
    check("vc1_idle_send_err",   32'(protoErr),          32'b11110);
    check("vc1_idle_send_avail", 32'(outVCAvailable[1]), 32'd1);

    // Non-one-hot VC field: nothing is debited, named VCs are flagged
    flitOutValid = 1'b1;
    flitOutVC    = 5'b00101;
    tick();
    idle_inputs();
    check("multihot_err", 32'(protoErr),  32'b11111);
    check("multihot_cnt", 32'(creditCnt), 32'({3'd4, 3'd0, 3'd4, 3'd3, 3'd2}));

    // Reset mid-packet discards everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_avail",  32'(outVCAvailable), 32'h1f);
    check("rst2_credit", 32'(outVCHasCredit), 32'h1f);
    check("rst2_err",    32'(protoErr),       32'h0);
    check("rst2_cnt",    32'(creditCnt),      32'({3'd4, 3'd4, 3'd4, 3'd4, 3'd4}));
    check("rst2_state",  32'(state_dbg),      32'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
